// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit.
//   state_t   - FSM state encoding
//   F3_*      - RISC-V funct3 width/sign codes
//   SZ_*      - access size encoded by funct3[1:0]
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RMW_RD,
    WR,
    RESP
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic for the load/store unit.
//   req_we/req_funct3/req_addr_lo -> illegal, misaligned (raw, before masking policy)
//   funct3/addr_lo/word           -> load_data (lane extract + sign/zero extend)
//   funct3/addr_lo/word/wdata     -> merged (word with target lanes replaced by wdata)
module lsu_align
  import lsu_pkg::*;
(
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [1:0]  req_addr_lo,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged,
  output logic        misaligned,
  output logic        illegal
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    illegal = 1'b1;
    case (req_funct3)
      F3_B, F3_H, F3_W: illegal = 1'b0;
      F3_BU, F3_HU:     illegal = req_we;
      default:          illegal = 1'b1;
    endcase

    // Alignment is only meaningful for a decodable width.
    misaligned = 1'b0;
    if (!illegal) begin
      case (req_funct3[1:0])
        SZ_H:    misaligned = req_addr_lo[0];
        SZ_W:    misaligned = |req_addr_lo;
        default: misaligned = 1'b0;
      endcase
    end
  end

  always_comb begin
    byte_v = word[{addr_lo, 3'b000} +: 8];
    half_v = addr_lo[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    load_data = {{24{byte_v[7]}}, byte_v};
      F3_BU:   load_data = {24'h000000, byte_v};
      F3_H:    load_data = {{16{half_v[15]}}, half_v};
      F3_HU:   load_data = {16'h0000, half_v};
      default: load_data = word;
    endcase
  end

  always_comb begin
    merged = word;
    case (funct3[1:0])
      SZ_B: merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      SZ_H: begin
        if (addr_lo[1]) merged[31:16] = wdata[15:0];
        else            merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of a word-only data memory for RISC-V
// lb/lh/lw/lbu/lhu/sb/sh/sw. Sub-word stores are read-modify-write.
//   req_*   - request handshake from the datapath (req_ready high only in IDLE)
//   resp_*  - one-cycle completion pulse with load data and fault flags
//   mem_*   - word-addressed memory, async read (mem_dout), sync write
// All outputs are registered; nothing on the memory side is combinational
// from req_*.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W            = 32,
  parameter bit          FAULT_ON_MISALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_misaligned,
  output logic              resp_illegal,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [31:0]       mem_dout
);

  state_t            state;
  logic [2:0]        f3_q;
  logic [1:0]        addr_lo_q;
  logic [31:0]       wdata_q;
  logic [ADDR_W-1:0] acc_addr;
  logic              raw_mis;
  logic              req_mis;
  logic              req_ill;
  logic [31:0]       load_data;
  logic [31:0]       merged;

  lsu_align u_align (
    .req_we      (req_we),
    .req_funct3  (req_funct3),
    .req_addr_lo (req_addr[1:0]),
    .funct3      (f3_q),
    .addr_lo     (addr_lo_q),
    .word        (mem_dout),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merged      (merged),
    .misaligned  (raw_mis),
    .illegal     (req_ill)
  );

  // With faulting disabled, misaligned addresses are forced to natural alignment.
  always_comb begin
    acc_addr = req_addr;
    if (!FAULT_ON_MISALIGN) begin
      case (req_funct3[1:0])
        SZ_H:    acc_addr[0]   = 1'b0;
        SZ_W:    acc_addr[1:0] = 2'b00;
        default: acc_addr      = req_addr;
      endcase
    end
    req_mis = FAULT_ON_MISALIGN && raw_mis;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      f3_q            <= '0;
      addr_lo_q       <= '0;
      wdata_q         <= '0;
      req_ready       <= 1'b1;
      resp_valid      <= 1'b0;
      resp_rdata      <= '0;
      resp_misaligned <= 1'b0;
      resp_illegal    <= 1'b0;
      mem_addr        <= '0;
      mem_din         <= '0;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            f3_q      <= req_funct3;
            addr_lo_q <= acc_addr[1:0];
            wdata_q   <= req_wdata;
            if (req_ill || req_mis) begin
              resp_valid      <= 1'b1;
              resp_rdata      <= '0;
              resp_illegal    <= req_ill;
              resp_misaligned <= req_mis;
              state           <= RESP;
            end else begin
              mem_addr <= {acc_addr[ADDR_W-1:2], 2'b00};
              if (!req_we) begin
                mem_read <= 1'b1;
                state    <= RD;
              end else if (req_funct3 == F3_W) begin
                mem_write <= 1'b1;
                mem_din   <= req_wdata;
                state     <= WR;
              end else begin
                mem_read <= 1'b1;
                state    <= RMW_RD;
              end
            end
          end
        end
        RD: begin
          mem_read   <= 1'b0;
          mem_addr   <= '0;
          resp_valid <= 1'b1;
          resp_rdata <= load_data;
          state      <= RESP;
        end
        RMW_RD: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b1;
          mem_din   <= merged;
          state     <= WR;
        end
        WR: begin
          mem_write  <= 1'b0;
          mem_din    <= '0;
          mem_addr   <= '0;
          resp_valid <= 1'b1;
          resp_rdata <= '0;
          state      <= RESP;
        end
        RESP: begin
          resp_valid      <= 1'b0;
          resp_rdata      <= '0;
          resp_misaligned <= 1'b0;
          resp_illegal    <= 1'b0;
          req_ready       <= 1'b1;
          state           <= IDLE;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
